// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the up and down counter families.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Codes A..F are not decimal; treat them as the largest legal digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter: load, step down with 0 -> 9 wrap, zero flag.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       step_in,
  output logic [3:0] d,
  output logic       is_zero
);

  bcd_digit_t d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (load) begin
      d_d = bcd_sanitize(load_d);
    end else if (step_in) begin
      d_d = (d_q == BCD_ZERO) ? BCD_MAX : d_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      d_q <= BCD_ZERO;
    end else begin
      d_q <= d_d;
    end
  end

  assign d       = d_q;
  assign is_zero = (d_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with zero flag and registered terminal-count pulse.
// Define BCD_DOWN_HOLD_AT_ZERO_EN to saturate at 0 instead of wrapping to all 9s.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  zero,
  output logic                  tc
);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] step_in;
  logic              en_eff;
  logic              q_is_one;
  logic              tc_q, tc_d;

  assign zero = &is_zero;

`ifdef BCD_DOWN_HOLD_AT_ZERO_EN
  assign en_eff = en & ~zero;
`else
  assign en_eff = en;
`endif

  // Borrow ripples combinationally: digit k steps only when all lower digits are 0.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign step_in[k] = en_eff;
    end else begin : g_upper
      assign step_in[k] = step_in[k-1] & is_zero[k-1];
    end

    bcd_down_digit u_digit (
      .clk     (clk),
      .clear_n (clear_n),
      .load    (load),
      .load_d  (load_val[4*k +: 4]),
      .step_in (step_in[k]),
      .d       (Q[4*k +: 4]),
      .is_zero (is_zero[k])
    );
  end

  assign q_is_one = (Q == (4*DIGITS)'(1));
  assign tc_d     = ~load & en & q_is_one;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Randomised self-checking bench for bcd_down_counter (2-digit and 4-digit instances).
module tb_bcd_down_counter;

`ifdef BCD_DOWN_HOLD_AT_ZERO_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_n;
  logic        en2, load2, zero2, tc2;
  logic [7:0]  lv2, q2;
  logic        en4, load4, zero4, tc4;
  logic [15:0] lv4, q4;

  int n_checks = 0;
  int n_pass   = 0;

  int m2_q, m4_q;
  bit m2_tc, m4_tc;

  bcd_down_counter #(.DIGITS(2)) dut2 (
    .clk(clk), .clear_n(clear_n), .en(en2), .load(load2), .load_val(lv2),
    .Q(q2), .zero(zero2), .tc(tc2)
  );

  bcd_down_counter #(.DIGITS(4)) dut4 (
    .clk(clk), .clear_n(clear_n), .en(en4), .load(load4), .load_val(lv4),
    .Q(q4), .zero(zero4), .tc(tc4)
  );

  function automatic int sanitize_val(input logic [31:0] b, input int nd);
    int v = 0;
    int w = 1;
    for (int k = 0; k < nd; k++) begin
      int dg;
      dg = int'(b[4*k +: 4]);
      if (dg > 9) dg = 9;
      v += dg * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick2(input bit l, input bit e, input logic [7:0] v);
    load2 = l; en2 = e; lv2 = v;
    @(posedge clk);
    if (l) begin
      m2_q = sanitize_val({24'b0, v}, 2); m2_tc = 1'b0;
    end else if (e) begin
      m2_tc = (m2_q == 1);
      m2_q  = (m2_q == 0) ? (HOLD ? 0 : 99) : m2_q - 1;
    end else begin
      m2_tc = 1'b0;
    end
    @(negedge clk);
    load2 = 1'b0; en2 = 1'b0;
  endtask

  task automatic tick4(input bit l, input bit e, input logic [15:0] v);
    load4 = l; en4 = e; lv4 = v;
    @(posedge clk);
    if (l) begin
      m4_q = sanitize_val({16'b0, v}, 4); m4_tc = 1'b0;
    end else if (e) begin
      m4_tc = (m4_q == 1);
      m4_q  = (m4_q == 0) ? (HOLD ? 0 : 9999) : m4_q - 1;
    end else begin
      m4_tc = 1'b0;
    end
    @(negedge clk);
    load4 = 1'b0; en4 = 1'b0;
  endtask

  // Every digit of both counters must stay in 0..9 on every cycle.
  always @(negedge clk) begin
    if (clear_n === 1'b1) begin
      bit bad;
      bad = 1'b0;
      for (int k = 0; k < 2; k++) if (q2[4*k +: 4] > 4'd9) bad = 1'b1;
      for (int k = 0; k < 4; k++) if (q4[4*k +: 4] > 4'd9) bad = 1'b1;
      n_checks++;
      if (bad) $display("FAIL non_bcd q2=%h q4=%h required all digits 0..9", q2, q4);
      else n_pass++;
    end
  end

  task automatic test_reset;
    clear_n = 1'b0;
    en2 = 0; load2 = 0; lv2 = '0; en4 = 0; load4 = 0; lv4 = '0;
    m2_q = 0; m2_tc = 0; m4_q = 0; m4_tc = 0;
    #3;
    n_checks++; if (q2 !== 8'h00) $display("FAIL reset_q2 got=%h want=00", q2); else n_pass++;
    n_checks++; if (zero2 !== 1'b1) $display("FAIL reset_zero2 got=%b want=1", zero2); else n_pass++;
    n_checks++; if (tc2 !== 1'b0) $display("FAIL reset_tc2 got=%b want=0", tc2); else n_pass++;
    n_checks++; if (q4 !== 16'h0000) $display("FAIL reset_q4 got=%h want=0000", q4); else n_pass++;
    @(negedge clk);
    clear_n = 1'b1;

    // Reset asserted between edges while counting at 37
    tick2(1'b1, 1'b0, 8'h37);
    n_checks++; if (q2 !== 8'h37) $display("FAIL load37 got=%h want=37", q2); else n_pass++;
    #2 clear_n = 1'b0;
    #1;
    n_checks++; if (q2 !== 8'h00) $display("FAIL midreset_q got=%h want=00", q2); else n_pass++;
    n_checks++; if (zero2 !== 1'b1) $display("FAIL midreset_zero got=%b want=1", zero2); else n_pass++;
    n_checks++; if (tc2 !== 1'b0) $display("FAIL midreset_tc got=%b want=0", tc2); else n_pass++;
    m2_q = 0; m2_tc = 0; m4_q = 0; m4_tc = 0;
    #1 clear_n = 1'b1;
    @(negedge clk);

    // A pending tc pulse is dropped by reset
    tick2(1'b1, 1'b0, 8'h01);
    tick2(1'b0, 1'b1, 8'h00);
    n_checks++; if (tc2 !== 1'b1) $display("FAIL pending_tc got=%b want=1", tc2); else n_pass++;
    #2 clear_n = 1'b0;
    #1;
    n_checks++; if (tc2 !== 1'b0) $display("FAIL tc_drop got=%b want=0", tc2); else n_pass++;
    m2_q = 0; m2_tc = 0; m4_q = 0; m4_tc = 0;
    #1 clear_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decrement;
    logic [7:0] exp_seq [3] = '{8'h20, 8'h19, 8'h18};
    tick2(1'b1, 1'b0, 8'h21);
    for (int i = 0; i < 3; i++) begin
      tick2(1'b0, 1'b1, 8'h00);
      n_checks++;
      if (q2 !== exp_seq[i]) $display("FAIL decrement_%0d got=%h want=%h", i, q2, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_terminal;
    logic [7:0] after_zero;
    after_zero = HOLD ? 8'h00 : 8'h99;
    tick2(1'b1, 1'b0, 8'h02);
    tick2(1'b0, 1'b1, 8'h00);
    n_checks++; if (q2 !== 8'h01 || tc2 !== 1'b0) $display("FAIL tc_step1 got q=%h tc=%b want q=01 tc=0", q2, tc2); else n_pass++;
    tick2(1'b0, 1'b1, 8'h00);
    n_checks++; if (q2 !== 8'h00 || tc2 !== 1'b1 || zero2 !== 1'b1) $display("FAIL tc_step2 got q=%h tc=%b zero=%b want q=00 tc=1 zero=1", q2, tc2, zero2); else n_pass++;
    tick2(1'b0, 1'b1, 8'h00);
    n_checks++; if (q2 !== after_zero || tc2 !== 1'b0) $display("FAIL tc_step3 got q=%h tc=%b want q=%h tc=0", q2, tc2, after_zero); else n_pass++;
    tick2(1'b0, 1'b0, 8'h00);
    n_checks++; if (tc2 !== 1'b0) $display("FAIL tc_idle got=%b want=0", tc2); else n_pass++;
  endtask

  task automatic test_priority;
    tick2(1'b1, 1'b1, 8'h3C);
    n_checks++; if (q2 !== 8'h39 || tc2 !== 1'b0) $display("FAIL prio_load got q=%h tc=%b want q=39 tc=0", q2, tc2); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick2(1'b0, 1'b0, 8'($urandom));
      n_checks++;
      if (q2 !== 8'h39 || zero2 !== 1'b0) $display("FAIL hold_%0d got q=%h zero=%b want q=39 zero=0", i, q2, zero2);
      else n_pass++;
    end
  endtask

  task automatic test_scaling;
    logic [31:0] exp_q;
    tick4(1'b1, 1'b0, 16'h1000);
    tick4(1'b0, 1'b1, 16'h0000);
    n_checks++; if (q4 !== 16'h0999 || zero4 !== 1'b0 || tc4 !== 1'b0) $display("FAIL scale_1000 got q=%h zero=%b tc=%b want q=0999", q4, zero4, tc4); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      bit l, e;
      logic [15:0] v;
      l = ($urandom % 6) == 0;
      e = ($urandom % 4) != 0;
      v = (($urandom % 2) == 0) ? 16'($urandom % 3) : 16'($urandom);
      tick4(l, e, v);
      exp_q = to_bcd(m4_q, 4);
      n_checks++;
      if (q4 !== exp_q[15:0] || zero4 !== (m4_q == 0) || tc4 !== m4_tc)
        $display("FAIL rand4_%0d got q=%h zero=%b tc=%b want q=%h zero=%b tc=%b",
                 i, q4, zero4, tc4, exp_q[15:0], (m4_q == 0), m4_tc);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_q;
    for (int i = 0; i < 300; i++) begin
      bit l, e;
      logic [7:0] v;
      l = ($urandom % 8) == 0;
      e = ($urandom % 4) != 0;
      v = (($urandom % 2) == 0) ? 8'($urandom % 4) : 8'($urandom);
      tick2(l, e, v);
      exp_q = to_bcd(m2_q, 2);
      n_checks++;
      if (q2 !== exp_q[7:0] || zero2 !== (m2_q == 0) || tc2 !== m2_tc)
        $display("FAIL rand2_%0d got q=%h zero=%b tc=%b want q=%h zero=%b tc=%b",
                 i, q2, zero2, tc2, exp_q[7:0], (m2_q == 0), m2_tc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_decrement();
    test_terminal();
    test_priority();
    test_scaling();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
